// File: rtl/car_ctrl_pkg.sv
// Shared constants for the car motion sequencer: widths, FSM encoding,
// config register map and sprite-core register addresses.
package car_ctrl_pkg;

  localparam int unsigned POS_W  = 11;
  localparam int unsigned VEL_W  = 8;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CFG_AW = 3;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_WR_X = 2'd2;
  localparam state_t ST_WR_Y = 2'd3;

  localparam logic [CFG_AW-1:0] CFG_CTRL = 3'd0;
  localparam logic [CFG_AW-1:0] CFG_DX   = 3'd1;
  localparam logic [CFG_AW-1:0] CFG_DY   = 3'd2;
  localparam logic [CFG_AW-1:0] CFG_XMIN = 3'd3;
  localparam logic [CFG_AW-1:0] CFG_XMAX = 3'd4;
  localparam logic [CFG_AW-1:0] CFG_YMIN = 3'd5;
  localparam logic [CFG_AW-1:0] CFG_YMAX = 3'd6;
  localparam logic [CFG_AW-1:0] CFG_RSVD = 3'd7;

  localparam logic [ADDR_W-1:0] SPR_ADDR_X0 = 14'h2001;
  localparam logic [ADDR_W-1:0] SPR_ADDR_Y0 = 14'h2002;

endpackage

// File: rtl/car_axis_step.sv
// One-axis position/velocity step with bounce or wrap at [min,max].
module car_axis_step
  import car_ctrl_pkg::*;
(
  input  logic [POS_W-1:0] pos_i,
  input  logic [VEL_W-1:0] d_i,
  input  logic [POS_W-1:0] min_i,
  input  logic [POS_W-1:0] max_i,
  input  logic             wrap_i,
  output logic [POS_W-1:0] pos_o,
  output logic [VEL_W-1:0] d_o
);

  localparam int unsigned SUM_W = POS_W + 1;

  logic signed [SUM_W-1:0] next_s;
  logic signed [SUM_W-1:0] min_s;
  logic signed [SUM_W-1:0] max_s;
  logic        [VEL_W-1:0] d_neg;

  assign next_s = $signed({1'b0, pos_i}) + $signed({{(SUM_W-VEL_W){d_i[VEL_W-1]}}, d_i});
  assign min_s  = $signed({1'b0, min_i});
  assign max_s  = $signed({1'b0, max_i});

  // The most negative velocity has no positive twin; clamp it instead.
  assign d_neg = (d_i == {1'b1, {(VEL_W-1){1'b0}}}) ? {1'b0, {(VEL_W-1){1'b1}}}
                                                    : VEL_W'(~d_i + VEL_W'(1));

  always_comb begin
    pos_o = next_s[POS_W-1:0];
    d_o   = d_i;
    if (next_s > max_s) begin
      pos_o = wrap_i ? min_i : max_i;
      d_o   = wrap_i ? d_i : d_neg;
    end else if (next_s < min_s) begin
      pos_o = wrap_i ? max_i : min_i;
      d_o   = wrap_i ? d_i : d_neg;
    end
  end

endmodule

// File: rtl/car_motion_ctrl.sv
// Per-frame sprite motion engine: steps x/y in vblank and writes x0/y0 to the
// sprite core over a bus shared with the CPU (CPU always has priority).
module car_motion_ctrl
  import car_ctrl_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned SPR_W    = 32,
  parameter int unsigned SPR_H    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [POS_W-1:0]  x,
  input  logic [POS_W-1:0]  y,
  input  logic              ctrl_cs,
  input  logic              ctrl_write,
  input  logic [CFG_AW-1:0] ctrl_addr,
  input  logic [DATA_W-1:0] ctrl_wr_data,
  input  logic              cpu_cs,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic              core_cs,
  output logic              core_write,
  output logic [ADDR_W-1:0] core_addr,
  output logic [DATA_W-1:0] core_wr_data,
  output logic [POS_W-1:0]  pos_x,
  output logic [POS_W-1:0]  pos_y,
  output logic              frame_done
);

  localparam logic [POS_W-1:0] X_MAX_RST = POS_W'(H_ACTIVE - SPR_W);
  localparam logic [POS_W-1:0] Y_MAX_RST = POS_W'(V_ACTIVE - SPR_H);

  state_t             state_q, state_d;
  logic               cond, cond_d_q, tick;
  logic               en_q, wrap_q, cfg_we, shadow_x, shadow_y;
  logic [VEL_W-1:0]   dx_q, dx_d, dy_q, dy_d, dx_step, dy_step;
  logic [POS_W-1:0]   pos_x_q, pos_x_d, pos_y_q, pos_y_d, x_step, y_step;
  logic [POS_W-1:0]   x_min_q, x_max_q, y_min_q, y_max_q;
  logic               unused_bits;

  assign unused_bits = ^{ctrl_wr_data[DATA_W-1:POS_W], cpu_addr[ADDR_W-2:2]};

  // Edge-detect the vblank point so a slow pixel enable still yields one tick.
  assign cond = (x == '0) && (y == POS_W'(V_ACTIVE));
  assign tick = cond & ~cond_d_q;

  assign cfg_we   = ctrl_cs & ctrl_write;
  assign shadow_x = cpu_cs & cpu_write & cpu_addr[ADDR_W-1] & (cpu_addr[1:0] == 2'b01);
  assign shadow_y = cpu_cs & cpu_write & cpu_addr[ADDR_W-1] & (cpu_addr[1:0] == 2'b10);

  car_axis_step u_step_x (
    .pos_i(pos_x_q), .d_i(dx_q), .min_i(x_min_q), .max_i(x_max_q), .wrap_i(wrap_q),
    .pos_o(x_step),  .d_o(dx_step)
  );

  car_axis_step u_step_y (
    .pos_i(pos_y_q), .d_i(dy_q), .min_i(y_min_q), .max_i(y_max_q), .wrap_i(wrap_q),
    .pos_o(y_step),  .d_o(dy_step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q    <= 1'b0;
      wrap_q  <= 1'b0;
      x_min_q <= '0;
      x_max_q <= X_MAX_RST;
      y_min_q <= '0;
      y_max_q <= Y_MAX_RST;
    end else if (cfg_we) begin
      case (ctrl_addr)
        CFG_CTRL: {wrap_q, en_q} <= ctrl_wr_data[1:0];
        CFG_XMIN: x_min_q        <= ctrl_wr_data[POS_W-1:0];
        CFG_XMAX: x_max_q        <= ctrl_wr_data[POS_W-1:0];
        CFG_YMIN: y_min_q        <= ctrl_wr_data[POS_W-1:0];
        CFG_YMAX: y_max_q        <= ctrl_wr_data[POS_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cond_d_q <= 1'b0;
      pos_x_q  <= '0;
      pos_y_q  <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
    end else begin
      state_q  <= state_d;
      cond_d_q <= cond;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: if (tick && en_q) state_d = ST_CALC;
      ST_CALC: state_d = ST_WR_X;
      ST_WR_X: if (!cpu_cs) state_d = ST_WR_Y;
      ST_WR_Y: begin
        if (!cpu_cs) begin
          frame_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Host writes land after the computed step so they override it in CALC.
  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    if (state_q == ST_CALC) begin
      pos_x_d = x_step;
      pos_y_d = y_step;
      dx_d    = dx_step;
      dy_d    = dy_step;
    end
    if (shadow_x) pos_x_d = cpu_wr_data[POS_W-1:0];
    if (shadow_y) pos_y_d = cpu_wr_data[POS_W-1:0];
    if (cfg_we && (ctrl_addr == CFG_DX)) dx_d = ctrl_wr_data[VEL_W-1:0];
    if (cfg_we && (ctrl_addr == CFG_DY)) dy_d = ctrl_wr_data[VEL_W-1:0];
  end

  always_comb begin
    core_cs      = 1'b0;
    core_write   = 1'b0;
    core_addr    = '0;
    core_wr_data = '0;
    if (cpu_cs) begin
      core_cs      = cpu_cs;
      core_write   = cpu_write;
      core_addr    = cpu_addr;
      core_wr_data = cpu_wr_data;
    end else if (state_q == ST_WR_X) begin
      core_cs      = 1'b1;
      core_write   = 1'b1;
      core_addr    = SPR_ADDR_X0;
      core_wr_data = DATA_W'(pos_x_q);
    end else if (state_q == ST_WR_Y) begin
      core_cs      = 1'b1;
      core_write   = 1'b1;
      core_addr    = SPR_ADDR_Y0;
      core_wr_data = DATA_W'(pos_y_q);
    end
  end

  assign pos_x = pos_x_q;
  assign pos_y = pos_y_q;

endmodule

// File: doc/car_motion_ctrl.md
Name: car_motion_ctrl

Overview:
- Autonomous motion sequencer for one car sprite core in a video slot.
- Once per frame, during vertical blanking, advances the sprite position by a programmed signed velocity, with bounce or wrap at programmable bounds.
- Writes the new x0/y0 to the sprite core's register space over the slot write bus.
- Arbitrates that bus with the CPU. The CPU always wins; the engine stalls.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines; frame tick is generated at line V_ACTIVE.
- SPR_W, 32, sprite width; default x_max = H_ACTIVE-SPR_W.
- SPR_H, 32, sprite height; default y_max = V_ACTIVE-SPR_H.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- x  in  11  frame counter column
- y  in  11  frame counter row
- ctrl_cs  in  1  selects this block's config registers
- ctrl_write  in  1  config write strobe
- ctrl_addr  in  3  config register index
- ctrl_wr_data  in  32  config write data
- cpu_cs  in  1  CPU select of sprite core
- cpu_write  in  1  CPU write strobe to sprite core
- cpu_addr  in  14  CPU address to sprite core
- cpu_wr_data  in  32  CPU write data to sprite core
- core_cs  out  1  to sprite core cs
- core_write  out  1  to sprite core write
- core_addr  out  14  to sprite core addr
- core_wr_data  out  32  to sprite core wr_data
- pos_x  out  11  current x position (shadow)
- pos_y  out  11  current y position (shadow)
- frame_done  out  1  one-cycle pulse when the y0 write completes

Behaviour:
- Config registers (write on ctrl_cs&ctrl_write), with reset values:
  - 0: ctrl. bit0 en, reset 0. bit1 wrap (1) / bounce (0), reset 0.
  - 1: dx, signed 8b from [7:0], reset 0.
  - 2: dy, signed 8b, reset 0.
  - 3: x_min, reset 0.
  - 4: x_max, reset H_ACTIVE-SPR_W.
  - 5: y_min, reset 0.
  - 6: y_max, reset V_ACTIVE-SPR_H.
  - 7: reserved, write ignored.
- Frame tick: cond = (x==0 && y==V_ACTIVE); tick = cond & ~cond_d. Exactly one pulse per frame regardless of pixel-enable rate.
- FSM states: IDLE, CALC, WR_X, WR_Y.
  - IDLE -> CALC on tick&en. Tick with en=0, or tick while not IDLE, is ignored.
  - CALC (1 cycle): registers the new pos/velocity for both axes.
  - WR_X: drives core write addr 14'h2001, data {21'b0,pos_x}. Advances only in a cycle with cpu_cs=0.
  - WR_Y: drives core write addr 14'h2002, data {21'b0,pos_y}. Advances when cpu_cs=0. On advance, frame_done=1 for that cycle -> IDLE.
  - Nominal latency with no CPU traffic: tick at T, CALC T+1, x0 write T+2, y0 write T+3.
- Axis step (identical per axis):
  - next = zero-extended 12b pos + sign-extended 12b d, compared signed.
  - Bounce mode:
    - next>max: pos=max, d=-d.
    - next<min: pos=min, d=-d.
    - Negation of -128 saturates to +127.
  - Wrap mode: next>max -> pos=min; next<min -> pos=max; d unchanged.
  - Otherwise pos=next.
  - min>max is not rejected: the >max test is applied first.
- Bus arbitration (combinational mux):
  - cpu_cs=1: core_* = cpu_* exactly.
  - Else in WR_X/WR_Y: engine drives cs=1, write=1.
  - Else all core_* = 0.
- Shadow coherence:
  - CPU write to addr[13]=1, addr[1:0]=01 loads pos_x from cpu_wr_data[10:0]; [1:0]=10 loads pos_y.
  - If this coincides with CALC, the CPU value wins over the computed value.
  - Likewise a config write to dx/dy in CALC wins over bounce negation.
- en cleared mid-sequence: the current sequence completes; no new sequence starts.
- Reset (async, any state): FSM=IDLE; pos_x=pos_y=0; frame_done=0; all core_* = 0 unless cpu_cs passes through; cond_d=0; config registers take their reset values.

Decomposition:
- Package car_ctrl_pkg:
  - state_t enum.
  - Config register index constants.
  - SPR_ADDR_X0=14'h2001, SPR_ADDR_Y0=14'h2002.
  - Sprite register field widths.
- Sub-module car_axis_step: purely combinational next pos/d for one axis, given pos, d, min, max, wrap. Instantiated twice.

Test Plan:
- Basic move: en=1, bounce, dx=3, dy=-2, pos=(100,200), frame tick -> writes 14'h2001 data 103 at T+2, 14'h2002 data 198 at T+3, frame_done at T+3.
- Bounce: pos_x=606, dx=5, x_max=608 -> pos_x=608, dx=-5. Next frame -> 603. dx=-128 at min -> dx=+127.
- Wrap: wrap=1, pos_x=2, dx=-4, x_min=0, x_max=608 -> pos_x=608, dx stays -4.
- Arbitration: hold cpu_cs=1 for 5 cycles from T+2 -> core_* mirrors CPU, engine x0 write occurs on the first cpu_cs=0 cycle, then y0; frame_done delayed accordingly.
- Shadow: CPU writes 14'h2001 data 50 in the CALC cycle -> pos_x=50, and the engine writes 50 to x0.
- Reset/enable: assert reset during WR_X -> core_cs=0, pos=(0,0), IDLE. With en=0, 3 frame ticks -> no core writes.
